// File: rtl/spi_burst_ctrl.sv
// Burst front-end for the SPI master core: TX/RX byte FIFOs plus an FSM that frames
// a whole TX backlog under one slave-select assertion and latches the clock config.
module spi_burst_ctrl #(
    parameter int DEPTH   = 8,
    parameter int SS_LEAD = 2,
    parameter int SS_LAG  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  logic [7:0]  wr_data_i,
    output logic        tx_full_o,
    input  logic        rd_en_i,
    output logic [7:0]  rd_data_o,
    output logic        rx_empty_o,
    output logic        rx_ovf_o,
    input  logic        clr_ovf_i,
    input  logic [15:0] cfg_dvsr_i,
    input  logic        cfg_cpol_i,
    input  logic        cfg_cpha_i,
    input  logic        go_i,
    output logic        busy_o,
    output logic        burst_done_o,
    output logic        ss_n_o,
    output logic [7:0]  spi_din_o,
    output logic        spi_start_o,
    output logic [15:0] spi_dvsr_o,
    output logic        spi_cpol_o,
    output logic        spi_cpha_o,
    input  logic        spi_ready_i,
    input  logic        spi_done_tick_i,
    input  logic [7:0]  spi_dout_i
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int CNT_MAX = (SS_LEAD > SS_LAG) ? SS_LEAD : SS_LAG;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_ISSUE, S_WAIT, S_LAG} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [7:0]         tx_mem [DEPTH];
    logic [AW-1:0]      tx_wp_q, tx_rp_q;
    logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
    logic               tx_full_q;

    logic [7:0]         rx_mem [DEPTH];
    logic [AW-1:0]      rx_wp_q, rx_rp_q, rx_rp_d;
    logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
    logic               rx_empty_q, rx_ovf_q;
    logic [7:0]         rd_data_q, rd_data_d;

    logic               ss_n_q, ss_n_d, busy_q, burst_done_q, burst_done_d;
    logic               start_q, start_d, cpol_q, cpha_q;
    logic [7:0]         din_q, din_d;
    logic [15:0]        dvsr_q;

    logic tx_push, tx_pop, tx_empty, rx_pop, rx_full, done_in_wait, rx_push, rx_drop, latch_cfg;

    assign tx_push      = wr_en_i && !tx_full_q;
    assign tx_empty     = (tx_cnt_q == '0);
    assign rx_pop       = rd_en_i && !rx_empty_q;
    assign rx_full      = (rx_cnt_q == CW'(DEPTH));
    assign done_in_wait = (state_q == S_WAIT) && spi_done_tick_i;
    // A pop in the same cycle frees the slot the incoming byte needs.
    assign rx_push      = done_in_wait && (!rx_full || rx_pop);
    assign rx_drop      = done_in_wait && !rx_push;

    assign tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    assign rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    assign rx_rp_d  = rx_rp_q + AW'(rx_pop);

    // NOTE: every variable written here gets a default first, so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_pop       = 1'b0;
        ss_n_d       = ss_n_q;
        start_d      = 1'b0;
        din_d        = din_q;
        burst_done_d = 1'b0;
        latch_cfg    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (go_i && !tx_empty) begin
                    state_d   = S_LEAD;
                    ss_n_d    = 1'b0;
                    latch_cfg = 1'b1;
                    cnt_d     = '0;
                end
            end
            S_LEAD: begin
                if (cnt_q == CNT_W'(SS_LEAD - 1)) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                if (spi_ready_i && !tx_empty) begin
                    start_d = 1'b1;
                    din_d   = tx_mem[tx_rp_q];
                    tx_pop  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A host write landing this cycle still extends the burst.
                if (spi_done_tick_i) begin
                    state_d = (!tx_empty || tx_push) ? S_ISSUE : S_LAG;
                    cnt_d   = '0;
                end
            end
            S_LAG: begin
                if (cnt_q == CNT_W'(SS_LAG - 1)) begin
                    state_d      = S_IDLE;
                    ss_n_d       = 1'b1;
                    burst_done_d = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FWFT head: the byte just pushed becomes the head only when it lands at the new read pointer.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rx_cnt_d != '0)
            rd_data_d = (rx_push && (rx_wp_q == rx_rp_d)) ? spi_dout_i : rx_mem[rx_rp_d];
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tx_wp_q      <= '0;
            tx_rp_q      <= '0;
            tx_cnt_q     <= '0;
            tx_full_q    <= 1'b0;
            rx_wp_q      <= '0;
            rx_rp_q      <= '0;
            rx_cnt_q     <= '0;
            rx_empty_q   <= 1'b1;
            rx_ovf_q     <= 1'b0;
            rd_data_q    <= '0;
            ss_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            burst_done_q <= 1'b0;
            start_q      <= 1'b0;
            din_q        <= '0;
            dvsr_q       <= '0;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_wp_q      <= tx_wp_q + AW'(tx_push);
            tx_rp_q      <= tx_rp_q + AW'(tx_pop);
            tx_cnt_q     <= tx_cnt_d;
            tx_full_q    <= (tx_cnt_d == CW'(DEPTH));
            rx_wp_q      <= rx_wp_q + AW'(rx_push);
            rx_rp_q      <= rx_rp_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_empty_q   <= (rx_cnt_d == '0);
            rx_ovf_q     <= rx_drop ? 1'b1 : (clr_ovf_i ? 1'b0 : rx_ovf_q);
            rd_data_q    <= rd_data_d;
            ss_n_q       <= ss_n_d;
            busy_q       <= (state_d != S_IDLE);
            burst_done_q <= burst_done_d;
            start_q      <= start_d;
            din_q        <= din_d;
            if (latch_cfg) begin
                dvsr_q <= cfg_dvsr_i;
                cpol_q <= cfg_cpol_i;
                cpha_q <= cfg_cpha_i;
            end
        end
    end

    // NOTE: storage arrays carry no reset; the pointers and counts alone define validity.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp_q] <= wr_data_i;
        if (rx_push) rx_mem[rx_wp_q] <= spi_dout_i;
    end

    assign tx_full_o    = tx_full_q;
    assign rd_data_o    = rd_data_q;
    assign rx_empty_o   = rx_empty_q;
    assign rx_ovf_o     = rx_ovf_q;
    assign busy_o       = busy_q;
    assign burst_done_o = burst_done_q;
    assign ss_n_o       = ss_n_q;
    assign spi_din_o    = din_q;
    assign spi_start_o  = start_q;
    assign spi_dvsr_o   = dvsr_q;
    assign spi_cpol_o   = cpol_q;
    assign spi_cpha_o   = cpha_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl: a loopback core model echoes each issued byte
// back on its done tick; all checks are hand-derived constants.
module tb_spi_burst_ctrl;

    localparam int DEPTH   = 8;
    localparam int SS_LEAD = 2;
    localparam int SS_LAG  = 2;
    localparam int LAT     = 3;

    logic        clk_i = 1'b0;
    logic        rst_i, wr_en_i, clr_ovf_i, go_i, cfg_cpol_i, cfg_cpha_i;
    logic [7:0]  wr_data_i;
    logic [15:0] cfg_dvsr_i;
    logic        host_rd, model_rd, rd_en_i;
    logic        tx_full_o, rx_empty_o, rx_ovf_o, busy_o, burst_done_o, ss_n_o;
    logic        spi_start_o, spi_cpol_o, spi_cpha_o;
    logic [7:0]  rd_data_o, spi_din_o;
    logic [15:0] spi_dvsr_o;
    logic        spi_ready_i, spi_done_tick_i;
    logic [7:0]  spi_dout_i;

    assign rd_en_i = host_rd | model_rd;

    spi_burst_ctrl #(.DEPTH(DEPTH), .SS_LEAD(SS_LEAD), .SS_LAG(SS_LAG)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .tx_full_o(tx_full_o),
        .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rx_empty_o(rx_empty_o),
        .rx_ovf_o(rx_ovf_o), .clr_ovf_i(clr_ovf_i),
        .cfg_dvsr_i(cfg_dvsr_i), .cfg_cpol_i(cfg_cpol_i), .cfg_cpha_i(cfg_cpha_i),
        .go_i(go_i), .busy_o(busy_o), .burst_done_o(burst_done_o), .ss_n_o(ss_n_o),
        .spi_din_o(spi_din_o), .spi_start_o(spi_start_o), .spi_dvsr_o(spi_dvsr_o),
        .spi_cpol_o(spi_cpol_o), .spi_cpha_o(spi_cpha_o),
        .spi_ready_i(spi_ready_i), .spi_done_tick_i(spi_done_tick_i), .spi_dout_i(spi_dout_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observers: cycle index advances on posedge; outputs sampled on negedge.
    int         pcyc = 0;
    int         n_start = 0, n_bdone = 0;
    int         cyc_ss_fall = 0, cyc_ss_rise = 0, cyc_first_start = 0, cyc_last_done = 0;
    logic       ss_prev = 1'b1, first_pending = 1'b0;
    logic [7:0] din_log[$];

    always @(posedge clk_i) begin
        pcyc <= pcyc + 1;
        if (spi_done_tick_i) cyc_last_done <= pcyc;
    end

    always @(negedge clk_i) begin
        ss_prev <= ss_n_o;
        if (ss_prev && !ss_n_o) begin
            cyc_ss_fall   <= pcyc;
            first_pending <= 1'b1;
        end
        if (!ss_prev && ss_n_o) cyc_ss_rise <= pcyc;
        if (spi_start_o) begin
            n_start <= n_start + 1;
            din_log.push_back(spi_din_o);
            if (first_pending) begin
                cyc_first_start <= pcyc;
                first_pending   <= 1'b0;
            end
        end
        if (burst_done_o) n_bdone <= n_bdone + 1;
    end

    // Loopback core model; optionally pops RX on a chosen done tick.
    int done_total  = 0;
    int pop_on_done = -1;

    initial begin
        logic [7:0] d;
        spi_ready_i     = 1'b1;
        spi_done_tick_i = 1'b0;
        spi_dout_i      = 8'h00;
        model_rd        = 1'b0;
        forever begin
            @(negedge clk_i);
            if (spi_start_o && !rst_i) begin
                d           = spi_din_o;
                spi_ready_i = 1'b0;
                repeat (LAT) @(negedge clk_i);
                done_total++;
                if (done_total == pop_on_done) model_rd = 1'b1;
                spi_dout_i      = d;
                spi_done_tick_i = 1'b1;
                @(negedge clk_i);
                spi_done_tick_i = 1'b0;
                model_rd        = 1'b0;
                spi_ready_i     = 1'b1;
            end
        end
    end

    task automatic push_byte(input logic [7:0] d);
        wr_data_i = d;
        wr_en_i   = 1'b1;
        @(negedge clk_i);
        wr_en_i   = 1'b0;
    endtask

    task automatic pulse_go();
        go_i = 1'b1;
        @(negedge clk_i);
        go_i = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {24'h0, rd_data_o}, {24'h0, exp});
        host_rd = 1'b1;
        @(negedge clk_i);
        host_rd = 1'b0;
    endtask

    task automatic wait_burst_done(input string tag);
        for (int k = 0; k < 2000; k++) begin
            if (burst_done_o) break;
            @(negedge clk_i);
        end
        check(tag, {31'h0, burst_done_o}, 32'h1);
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s0, b0, d0;
        rst_i = 1'b1; wr_en_i = 1'b0; wr_data_i = 8'h00; host_rd = 1'b0;
        clr_ovf_i = 1'b0; go_i = 1'b0; cfg_dvsr_i = 16'd4; cfg_cpol_i = 1'b0; cfg_cpha_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_flags", {25'h0, ss_n_o, rx_empty_o, tx_full_o, rx_ovf_o, busy_o, burst_done_o, spi_start_o},
              32'b1100000);
        check("reset_data", {8'h0, spi_din_o, rd_data_o, 8'h0}, 32'h0);
        check("reset_cfg", {14'h0, spi_dvsr_o, spi_cpol_o, spi_cpha_o}, 32'h0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Basic 3-byte burst with lead/lag framing
        push_byte(8'hA5); push_byte(8'h3C); push_byte(8'hFF);
        s0 = n_start; b0 = n_bdone;
        pulse_go();
        check("busy_after_go", {31'h0, busy_o}, 32'h1);
        wait_burst_done("b2_done");
        check("b2_starts", n_start - s0, 3);
        check("b2_din0", {24'h0, din_log[s0]},     32'hA5);
        check("b2_din1", {24'h0, din_log[s0 + 1]}, 32'h3C);
        check("b2_din2", {24'h0, din_log[s0 + 2]}, 32'hFF);
        check("b2_lead", cyc_first_start - cyc_ss_fall, SS_LEAD + 1);
        check("b2_lag", cyc_ss_rise - cyc_last_done, SS_LAG + 1);
        check("b2_bdone_pulses", n_bdone - b0, 1);
        check("b2_idle", {30'h0, ss_n_o, busy_o}, 32'b10);
        check("b2_dvsr", {16'h0, spi_dvsr_o}, 32'd4);
        pop_check("b2_rx0", 8'hA5); pop_check("b2_rx1", 8'h3C); pop_check("b2_rx2", 8'hFF);
        check("b2_rx_empty", {31'h0, rx_empty_o}, 32'h1);

        // TX full at DEPTH; extra byte dropped
        for (int i = 0; i < 8; i++) push_byte(8'(i));
        check("b3_full", {31'h0, tx_full_o}, 32'h1);
        push_byte(8'h08);
        check("b3_full_hold", {31'h0, tx_full_o}, 32'h1);
        s0 = n_start;
        pulse_go();
        wait_burst_done("b3_done");
        check("b3_starts", n_start - s0, 8);
        check("b3_din_last", {24'h0, din_log[s0 + 7]}, 32'h07);
        check("b3_not_full", {31'h0, tx_full_o}, 32'h0);
        for (int i = 0; i < 8; i++) pop_check($sformatf("b3_rx%0d", i), 8'(i));
        check("b3_rx_empty", {31'h0, rx_empty_o}, 32'h1);

        // RX overflow across two bursts, then clear
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
        pulse_go(); wait_burst_done("b4a_done");
        check("b4_no_ovf_yet", {31'h0, rx_ovf_o}, 32'h0);
        for (int i = 0; i < 5; i++) push_byte(8'h20 + 8'(i));
        pulse_go(); wait_burst_done("b4b_done");
        check("b4_ovf", {31'h0, rx_ovf_o}, 32'h1);
        for (int i = 0; i < 5; i++) pop_check($sformatf("b4_rxa%0d", i), 8'h10 + 8'(i));
        for (int i = 0; i < 3; i++) pop_check($sformatf("b4_rxb%0d", i), 8'h20 + 8'(i));
        check("b4_rx_empty", {31'h0, rx_empty_o}, 32'h1);
        clr_ovf_i = 1'b1; @(negedge clk_i); clr_ovf_i = 1'b0;
        check("b4_ovf_clr", {31'h0, rx_ovf_o}, 32'h0);

        // Ninth done tick coincides with a pop: no overflow
        for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
        pulse_go(); wait_burst_done("b4c_done");
        for (int i = 0; i < 4; i++) push_byte(8'h40 + 8'(i));
        pop_on_done = done_total + 4;
        pulse_go(); wait_burst_done("b4d_done");
        check("b4_pop_no_ovf", {31'h0, rx_ovf_o}, 32'h0);
        for (int i = 1; i < 5; i++) pop_check($sformatf("b4_rxc%0d", i), 8'h30 + 8'(i));
        for (int i = 0; i < 4; i++) pop_check($sformatf("b4_rxd%0d", i), 8'h40 + 8'(i));
        check("b4_rx_empty2", {31'h0, rx_empty_o}, 32'h1);

        // go with empty TX is ignored; cfg changes mid-burst have no effect
        pulse_go();
        repeat (3) @(negedge clk_i);
        check("b5_empty_go", {30'h0, ss_n_o, busy_o}, 32'b10);
        push_byte(8'h55); push_byte(8'h66); push_byte(8'h77);
        cfg_dvsr_i = 16'd4; cfg_cpol_i = 1'b0; cfg_cpha_i = 1'b0;
        pulse_go();
        cfg_dvsr_i = 16'd9; cfg_cpol_i = 1'b1; cfg_cpha_i = 1'b1;
        repeat (5) @(negedge clk_i);
        check("b5_mid_cfg", {14'h0, spi_dvsr_o, spi_cpol_o, spi_cpha_o}, {14'h0, 16'd4, 2'b00});
        wait_burst_done("b5_done");
        check("b5_end_dvsr", {16'h0, spi_dvsr_o}, 32'd4);
        pop_check("b5_rx0", 8'h55); pop_check("b5_rx1", 8'h66); pop_check("b5_rx2", 8'h77);
        push_byte(8'h88);
        pulse_go();
        check("b5_new_cfg", {14'h0, spi_dvsr_o, spi_cpol_o, spi_cpha_o}, {14'h0, 16'd9, 2'b11});
        wait_burst_done("b5b_done");
        pop_check("b5_rx3", 8'h88);

        // Reset after the first done tick of a 3-byte burst
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        d0 = done_total;
        pulse_go();
        for (int k = 0; k < 500; k++) begin
            @(posedge clk_i);
            if (done_total != d0) break;
        end
        check("b6_first_done", done_total - d0, 1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("b6_reset_state", {28'h0, ss_n_o, busy_o, rx_empty_o, tx_full_o}, 32'b1010);
        s0 = n_start;
        repeat (20) @(negedge clk_i);
        check("b6_no_start", n_start - s0, 0);
        check("b6_still_idle", {30'h0, ss_n_o, busy_o}, 32'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_burst_ctrl.md
Name: spi_burst_ctrl

Overview:
Upstream command/buffer stage for the SPI master core. It collects host bytes in a TX FIFO and, on a single go pulse, streams them through the core's start/din/ready/done handshake as one burst. Slave select is held low for the whole burst. Received bytes (core dout) are captured into an RX FIFO for the host. It also latches the SPI clock configuration (dvsr, cpol, cpha) that the core runs with.

Parameters:
DEPTH, 8, entries per FIFO (power of 2, >=2)
SS_LEAD, 2, cycles from ss_n_o falling to first spi_start_o (>=1)
SS_LAG, 2, cycles from last spi_done_tick_i to ss_n_o rising (>=1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
wr_en_i  in  1  push wr_data_i into TX FIFO
wr_data_i  in  8  TX byte
tx_full_o  out  1  TX FIFO full
rd_en_i  in  1  pop RX FIFO head
rd_data_o  out  8  RX FIFO head (first-word-fall-through)
rx_empty_o  out  1  RX FIFO empty
rx_ovf_o  out  1  sticky RX overflow flag
clr_ovf_i  in  1  clears rx_ovf_o
cfg_dvsr_i  in  16  SCLK divisor, latched at go
cfg_cpol_i  in  1  clock polarity, latched at go
cfg_cpha_i  in  1  clock phase, latched at go
go_i  in  1  start burst
busy_o  out  1  burst in progress (state != IDLE)
burst_done_o  out  1  1-cycle pulse when ss_n_o returns high
ss_n_o  out  1  active-low slave select
spi_din_o  out  8  to core din_i
spi_start_o  out  1  to core start_i
spi_dvsr_o  out  16  to core dvsr_i
spi_cpol_o  out  1  to core cpol_i
spi_cpha_o  out  1  to core cpha_i
spi_ready_i  in  1  from core ready_o
spi_done_tick_i  in  1  from core spi_done_tick_o
spi_dout_i  in  8  from core dout_o

Behaviour:
- Reset values: ss_n_o=1; rx_empty_o=1. tx_full_o, rx_ovf_o, busy_o, burst_done_o, spi_start_o=0. spi_din_o, spi_dvsr_o, spi_cpol_o, spi_cpha_o, rd_data_o=0. Both FIFOs empty; FSM in IDLE.
- All outputs are registered.
- TX push: accepted iff wr_en_i && !tx_full_o, using the registered flag. Otherwise the byte is dropped silently. Push and pop in the same cycle are legal; count is unchanged.
- RX pop: rd_en_i while rx_empty_o=1 is ignored. rd_data_o updates the cycle after a pop.
- RX push on spi_done_tick_i (WAIT state only): accepted if RX is not full, or if rd_en_i pops in the same cycle. Otherwise the byte is lost and rx_ovf_o=1.
- rx_ovf_o clears on clr_ovf_i. If a set and a clear occur in the same cycle, set wins.
- FSM:
  - IDLE: go_i && TX not empty -> LEAD. On this transition: latch cfg_* into spi_dvsr_o/cpol/cpha; ss_n_o=0 next cycle. go_i with TX empty is ignored. go_i while busy is ignored.
  - LEAD: count SS_LEAD cycles -> ISSUE.
  - ISSUE: when spi_ready_i && TX not empty:
    - pulse spi_start_o for exactly 1 cycle;
    - drive spi_din_o with the TX head and hold it until the next issue;
    - pop TX in the same cycle;
    - -> WAIT.
  - WAIT: on spi_done_tick_i, push spi_dout_i into RX. Then -> ISSUE if TX is not empty (checked after the same-cycle host push), else -> LAG.
  - LAG: count SS_LAG cycles. Then ss_n_o=1, burst_done_o pulses, -> IDLE.
- Host writes during a burst extend that burst if they land before the WAIT decision.
- spi_done_tick_i outside WAIT is ignored.
- cfg_* changes during a burst have no effect until the next go.
- Reset mid-burst: next cycle everything is at reset values, ss_n_o=1, both FIFOs flushed. The core shares rst_i.

Test Plan:
1. Assert rst_i 2 cycles -> all outputs at listed reset values; ss_n_o=1, rx_empty_o=1.
2. Write A5,3C,FF; cfg_dvsr_i=4, cpol=0, cpha=0; go_i. Core loops mosi to miso. Required response:
   - ss_n_o low SS_LEAD cycles before the first spi_start_o;
   - exactly 3 start pulses with spi_din_o A5,3C,FF;
   - RX reads A5,3C,FF in order;
   - ss_n_o high SS_LAG cycles after the 3rd done tick, plus one burst_done_o pulse.
3. DEPTH=8, write 9 bytes 00..08 -> tx_full_o=1 after the 8th write; 08 dropped; burst issues exactly 8 starts.
4. Two 5-byte bursts with no reads -> 8 stored, rx_ovf_o=1, RX reads the first 8 bytes. clr_ovf_i -> rx_ovf_o=0. Repeat with rd_en_i coincident with the 9th done tick -> no overflow.
5. go_i with TX empty -> ss_n_o stays 1, busy_o=0. During a burst with dvsr=4, drive cfg_dvsr_i=9 -> spi_dvsr_o stays 4 until the next go.
6. Assert rst_i after the 1st done tick of a 3-byte burst -> ss_n_o=1 next cycle, busy_o=0, rx_empty_o=1, no further spi_start_o.
